// File: rtl/slot_counter.sv
// Gen2 slot counter: tracks Q and the slot, issues the RN16 reply strobe and runs the ACK handshake.
// Optional REPLY timeout is compiled in when SLOT_COUNTER_TIMEOUT_EN is defined.
module slot_counter #(
    parameter int SLOT_W         = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              query_stb,
    input  logic              queryadj_stb,
    input  logic              queryrep_stb,
    input  logic              ack_stb,
    input  logic              nak_stb,
    input  logic [3:0]        q_in,
    input  logic [1:0]        updn,
    input  logic [15:0]       handle,
    input  logic [15:0]       ack_rn,
    output logic              reply_stb,
    output logic [1:0]        state,
    output logic [SLOT_W-1:0] slot,
    output logic [3:0]        q_out,
    output logic [15:0]       rn_latched
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        ARBITRATE    = 2'b01,
        REPLY        = 2'b10,
        ACKNOWLEDGED = 2'b11
    } state_t;

    state_t            cur_state, nxt_state;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_dec, slot_load;
    logic [3:0]        q_q, q_d, q_adj, load_q;
    logic [15:0]       rn_q, rn_d;
    logic              reply_q, reply_d;
    logic              load;
    logic              ack_match;
    logic              timeout_hit;

    assign slot_dec  = slot_q - SLOT_W'(1);
    assign ack_match = (ack_rn == rn_q);

    // QueryAdjust saturates at both ends of the Q range.
    always_comb begin
        q_adj = q_q;
        case (updn)
            2'b01:   q_adj = (q_q == 4'd15) ? q_q : q_q + 4'd1;
            2'b10:   q_adj = (q_q == 4'd0)  ? q_q : q_q - 4'd1;
            default: q_adj = q_q;
        endcase
    end

`ifdef SLOT_COUNTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts only while staying in REPLY; any (re)entry restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to_cnt <= '0;
        else if (cur_state == REPLY && nxt_state == REPLY && !reply_d)
            to_cnt <= to_cnt + TO_W'(1);
        else
            to_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        nxt_state = cur_state;
        slot_d    = slot_q;
        q_d       = q_q;
        rn_d      = rn_q;
        reply_d   = 1'b0;
        load      = 1'b0;
        load_q    = q_q;
        slot_load = '0;

        // Fixed priority: query > queryadj > queryrep > ack > nak > timeout.
        if (query_stb) begin
            load   = 1'b1;
            load_q = q_in;
        end else if (queryadj_stb) begin
            if (cur_state != IDLE) begin
                load   = 1'b1;
                load_q = q_adj;
            end
        end else if (queryrep_stb) begin
            case (cur_state)
                ARBITRATE: begin
                    slot_d = slot_dec;
                    if (slot_dec == '0) begin
                        nxt_state = REPLY;
                        reply_d   = 1'b1;
                    end
                end
                REPLY:        nxt_state = ARBITRATE;
                ACKNOWLEDGED: nxt_state = IDLE;
                default:      nxt_state = cur_state;
            endcase
        end else if (ack_stb) begin
            if (cur_state == REPLY || cur_state == ACKNOWLEDGED)
                nxt_state = ack_match ? ACKNOWLEDGED : ARBITRATE;
        end else if (nak_stb) begin
            if (cur_state != IDLE)
                nxt_state = ARBITRATE;
        end else if (cur_state == REPLY && timeout_hit) begin
            nxt_state = ARBITRATE;
        end

        if (load) begin
            slot_load = handle[SLOT_W-1:0] & ~({SLOT_W{1'b1}} << load_q);
            q_d       = load_q;
            rn_d      = handle;
            slot_d    = slot_load;
            if (slot_load == '0) begin
                nxt_state = REPLY;
                reply_d   = 1'b1;
            end else begin
                nxt_state = ARBITRATE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            cur_state <= IDLE;
            slot_q    <= '0;
            q_q       <= '0;
            rn_q      <= '0;
            reply_q   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            slot_q    <= slot_d;
            q_q       <= q_d;
            rn_q      <= rn_d;
            reply_q   <= reply_d;
        end
    end

    assign state      = cur_state;
    assign slot       = slot_q;
    assign q_out      = q_q;
    assign rn_latched = rn_q;
    assign reply_stb  = reply_q;

endmodule

// File: tb/tb_slot_counter.sv
// Scoreboard bench for slot_counter: directed strobes push expected outputs, a negedge monitor compares.
module tb_slot_counter;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ARB  = 2'b01;
    localparam logic [1:0] S_REP  = 2'b10;
    localparam logic [1:0] S_ACK  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        query_stb, queryadj_stb, queryrep_stb, ack_stb, nak_stb;
    logic [3:0]  q_in;
    logic [1:0]  updn;
    logic [15:0] handle, ack_rn;
    logic        reply_stb;
    logic [1:0]  state;
    logic [14:0] slot;
    logic [3:0]  q_out;
    logic [15:0] rn_latched;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        string       name;
        logic [37:0] exp;
    } exp_t;

    exp_t sb[$];

    slot_counter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .query_stb    (query_stb),
        .queryadj_stb (queryadj_stb),
        .queryrep_stb (queryrep_stb),
        .ack_stb      (ack_stb),
        .nak_stb      (nak_stb),
        .q_in         (q_in),
        .updn         (updn),
        .handle       (handle),
        .ack_rn       (ack_rn),
        .reply_stb    (reply_stb),
        .state        (state),
        .slot         (slot),
        .q_out        (q_out),
        .rn_latched   (rn_latched)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {state,slot,q,rn,rep}=%h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(e.name, {state, slot, q_out, rn_latched, reply_stb}, e.exp);
        end
    end

    task automatic clear_strobes();
        query_stb    = 1'b0;
        queryadj_stb = 1'b0;
        queryrep_stb = 1'b0;
        ack_stb      = 1'b0;
        nak_stb      = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; the expectation is for after the next posedge.
    task automatic step(input string nm, input logic [1:0] es, input logic [14:0] eslot,
                        input logic [3:0] eq, input logic [15:0] ern, input logic erep);
        exp_t e;
        e.due  = cyc + 1;
        e.name = nm;
        e.exp  = {es, eslot, eq, ern, erep};
        sb.push_back(e);
        @(negedge clk);
        clear_strobes();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        clear_strobes();
        q_in = 4'd0; updn = 2'b00; handle = 16'h0000; ack_rn = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step("reset_state", S_IDLE, 15'h0000, 4'd0, 16'h0000, 1'b0);

        query_stb = 1'b1; q_in = 4'd4; handle = 16'hABCD;
        step("query_q4_abcd", S_ARB, 15'h000D, 4'd4, 16'hABCD, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_dec_c", S_ARB, 15'h000C, 4'd4, 16'hABCD, 1'b0);

        query_stb = 1'b1; q_in = 4'd2; handle = 16'h0006;
        step("query_slot2", S_ARB, 15'h0002, 4'd2, 16'h0006, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_slot1", S_ARB, 15'h0001, 4'd2, 16'h0006, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_slot0_reply", S_REP, 15'h0000, 4'd2, 16'h0006, 1'b1);
        step("reply_stb_one_cycle", S_REP, 15'h0000, 4'd2, 16'h0006, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_in_reply", S_ARB, 15'h0000, 4'd2, 16'h0006, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_wrap_7fff", S_ARB, 15'h7FFF, 4'd2, 16'h0006, 1'b0);

        query_stb = 1'b1; q_in = 4'd0; handle = 16'h1234;
        step("query_q0_reply", S_REP, 15'h0000, 4'd0, 16'h1234, 1'b1);
        ack_stb = 1'b1; ack_rn = 16'h1234;
        step("ack_match", S_ACK, 15'h0000, 4'd0, 16'h1234, 1'b0);
        queryrep_stb = 1'b1;
        step("rep_in_ack_idle", S_IDLE, 15'h0000, 4'd0, 16'h1234, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b01; handle = 16'hFFFF;
        step("adj_ignored_idle", S_IDLE, 15'h0000, 4'd0, 16'h1234, 1'b0);

        query_stb = 1'b1; q_in = 4'd0; handle = 16'h5555;
        step("query_q0_5555", S_REP, 15'h0000, 4'd0, 16'h5555, 1'b1);
        ack_stb = 1'b1; ack_rn = 16'h5554;
        step("ack_mismatch", S_ARB, 15'h0000, 4'd0, 16'h5555, 1'b0);
        nak_stb = 1'b1;
        step("nak_in_arb", S_ARB, 15'h0000, 4'd0, 16'h5555, 1'b0);
        ack_stb = 1'b1; ack_rn = 16'h5555;
        step("ack_ignored_arb", S_ARB, 15'h0000, 4'd0, 16'h5555, 1'b0);

        query_stb = 1'b1; q_in = 4'd15; handle = 16'hFFFF;
        step("query_q15", S_ARB, 15'h7FFF, 4'd15, 16'hFFFF, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b01; handle = 16'h8001;
        step("adj_up_sat15", S_ARB, 15'h0001, 4'd15, 16'h8001, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b10; handle = 16'h00F3;
        step("adj_down_q14", S_ARB, 15'h00F3, 4'd14, 16'h00F3, 1'b0);
        query_stb = 1'b1; q_in = 4'd1; handle = 16'h0003;
        step("query_q1", S_ARB, 15'h0001, 4'd1, 16'h0003, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b10; handle = 16'h0007;
        step("adj_down_q0", S_REP, 15'h0000, 4'd0, 16'h0007, 1'b1);
        queryadj_stb = 1'b1; updn = 2'b10; handle = 16'hBEEF;
        step("adj_down_sat0", S_REP, 15'h0000, 4'd0, 16'hBEEF, 1'b1);
        ack_stb = 1'b1; ack_rn = 16'hBEEF;
        step("ack_match_beef", S_ACK, 15'h0000, 4'd0, 16'hBEEF, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b01; handle = 16'h0003;
        step("adj_from_ack", S_ARB, 15'h0001, 4'd1, 16'h0003, 1'b0);
        queryadj_stb = 1'b1; updn = 2'b11; handle = 16'h0002;
        step("adj_hold_q", S_REP, 15'h0000, 4'd1, 16'h0002, 1'b1);
        nak_stb = 1'b1;
        step("nak_in_reply", S_ARB, 15'h0000, 4'd1, 16'h0002, 1'b0);

        query_stb = 1'b1; queryrep_stb = 1'b1; ack_stb = 1'b1;
        q_in = 4'd3; handle = 16'h0009; ack_rn = 16'h0002;
        step("prio_query_wins", S_ARB, 15'h0001, 4'd3, 16'h0009, 1'b0);
        queryrep_stb = 1'b1; nak_stb = 1'b1;
        step("prio_rep_over_nak", S_REP, 15'h0000, 4'd3, 16'h0009, 1'b1);
        step("reply_idle", S_REP, 15'h0000, 4'd3, 16'h0009, 1'b0);
        ack_stb = 1'b1; nak_stb = 1'b1; ack_rn = 16'h0009;
        step("prio_ack_over_nak", S_ACK, 15'h0000, 4'd3, 16'h0009, 1'b0);
        queryrep_stb = 1'b1;
        step("ack_rep_idle", S_IDLE, 15'h0000, 4'd3, 16'h0009, 1'b0);

        query_stb = 1'b1; q_in = 4'd0; handle = 16'h4242;
        step("timeout_enter", S_REP, 15'h0000, 4'd0, 16'h4242, 1'b1);
`ifdef SLOT_COUNTER_TIMEOUT_EN
        for (int i = 1; i < 64; i++)
            step("timeout_hold", S_REP, 15'h0000, 4'd0, 16'h4242, 1'b0);
        step("timeout_expire", S_ARB, 15'h0000, 4'd0, 16'h4242, 1'b0);
`else
        for (int i = 0; i < 1000; i++)
            step("no_timeout_hold", S_REP, 15'h0000, 4'd0, 16'h4242, 1'b0);
`endif

        query_stb = 1'b1; q_in = 4'd0; handle = 16'h7777;
        step("reply_before_reset", S_REP, 15'h0000, 4'd0, 16'h7777, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", {state, slot, q_out, rn_latched, reply_stb}, 38'd0);
        @(negedge clk);
        step("reset_held", S_IDLE, 15'h0000, 4'd0, 16'h0000, 1'b0);
        reset_n = 1'b1;

        query_stb = 1'b1; q_in = 4'd4; handle = 16'h0010;
        step("post_reset_query", S_REP, 15'h0000, 4'd4, 16'h0010, 1'b1);
        nak_stb = 1'b1;
        step("post_reset_nak", S_ARB, 15'h0000, 4'd4, 16'h0010, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 38'(sb.size()), 38'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
